stream_pack_fifo: RTL
=====================

Name: stream_pack_fifo

Overview:
Parametrised successor to the camera-side 8-to-64 packer/FIFO. It runs in a single clock domain. It packs RATIO narrow input beats of IN_W bits into one OUT_W = IN_W*RATIO word and buffers the words in an internal first-word-fall-through FIFO for the DMA/burst writer. Over the current block it adds:
- configurable lane order;
- a flush that pushes partial words;
- start/stop control;
- a sticky overflow flag for dropped beats;
- a parametrised burst threshold.

Parameters:
IN_W, 8, input beat width in bits
RATIO, 8, beats per output word (>=2)
DEPTH, 1024, FIFO depth in output words (power of 2)
BURST_LEN, 16, minimum stored words for burst_valid
LSB_FIRST, 1, 1: beat 0 in bits [IN_W-1:0]; 0: beat 0 in the MSB lane
CNT_W, $clog2(DEPTH)+1, fifo_cnt width

Ports:
pclk  input  1  clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse: enable capture, clear overflow
stop  input  1  pulse: disable capture
flush  input  1  pulse: push pending partial word, zero-padded
din_valid  input  1  input beat valid
din_ready  output  1  input beat can be accepted
din  input  IN_W  input beat
dout  output  IN_W*RATIO  head-of-FIFO word (FWFT)
dout_valid  output  1  FIFO non-empty
dout_ready  input  1  consumer pops head when dout_valid high
burst_valid  output  1  fifo_cnt >= BURST_LEN
fifo_cnt  output  CNT_W  stored words, 0..DEPTH
overflow  output  1  sticky: a beat was offered while running and not accepted
running  output  1  capture enabled

Behaviour:
- Reset (async, rst_n low): running=0, lane=0, the push register is empty, FIFO pointers and count are 0, overflow=0.
  - Outputs under reset: din_ready=0, dout_valid=0, burst_valid=0, fifo_cnt=0.
  - dout is don't-care while dout_valid=0.
  - Reset mid-operation discards partial lanes and all stored words.
- Start/stop:
  - start sets running. start while already running has no effect except clearing overflow.
  - stop clears running.
  - start and stop in the same cycle: stop wins, and overflow is still cleared.
  - stop keeps partial lanes; a later start resumes at the same lane.
- Accept:
  - A beat is accepted when din_valid && din_ready.
  - din_ready = running && space.
  - space = (fifo_cnt + push_pending) < DEPTH, where push_pending=1 while the push register holds a word.
- Packing:
  - An accepted beat is written into lane `lane`, then lane increments.
  - Beat 0 position: LSB_FIRST=1 puts it in bits [IN_W-1:0]; LSB_FIRST=0 puts it in the top lane.
  - On the beat that fills lane RATIO-1, the complete word is loaded into the push register and lane wraps to 0.
- Push timing:
  - The push register writes the FIFO on the next edge.
  - If the last beat is accepted at edge E, fifo_cnt increments and dout_valid rises after edge E+1. Latency is 1 cycle.
- Flush:
  - flush is sampled each cycle; a beat accepted in the same cycle is included first.
  - If lane>0 after that, the partial word is loaded into the push register, with unfilled lanes set to 0, and lane returns to 0.
  - If lane==0 (including when the beat just completed a word), flush does nothing extra.
  - If there is no space, the flush request is held pending with din_ready=0 until it is pushed.
  - flush is effective whether or not running is set.
- FIFO:
  - dout is combinationally the entry at the read pointer.
  - A pop occurs when dout_valid && dout_ready; a pop while empty is ignored.
  - Push and pop in the same cycle leave fifo_cnt unchanged.
  - Pointers wrap modulo DEPTH. fifo_cnt reaches DEPTH exactly when full.
  - A push is never issued while full; the space term guarantees this.
- burst_valid is combinational from fifo_cnt. It never glitches at the threshold during a simultaneous push and pop.
- overflow:
  - Set on any cycle where running && din_valid && !din_ready.
  - Held until start or reset.
  - Dropped beats do not advance lane.

Test Plan:
1. Defaults, start, 16 beats 0x00..0x0F back-to-back, dout_ready=0 -> fifo_cnt=2 one cycle after the 16th beat, dout=0x0706050403020100, then after a pop 0x0F0E0D0C0B0A0908. burst_valid stays 0.
2. LSB_FIRST=0, beats 0x11..0x88 -> dout=0x1122334455667788.
3. 3 beats 0xAA,0xBB,0xCC, then flush -> one word 0x0000000000CCBBAA; lane restarts at 0. A flush with lane==0 produces no push.
4. DEPTH=4, dout_ready=0, 40 beats -> fifo_cnt=4, din_ready=0 after the 32nd beat, overflow=1 from the 33rd offered beat. start clears overflow. Popping one word restores din_ready.
5. BURST_LEN=16, fill 16 words -> burst_valid=1 when fifo_cnt=16. Simultaneous push and pop at 16 keeps it at 1. Pop to 15 -> 0.
6. rst_n low mid-word with 5 words stored -> all outputs at reset values immediately, running=0. After release and start, the first word packs from lane 0.

Source files
------------

// File: rtl/stream_pack_fifo.sv
// Packs RATIO narrow beats into one wide word and queues the words in a
// first-word-fall-through FIFO, with flush, start/stop and overflow tracking.
module stream_pack_fifo #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 8,
    parameter int DEPTH     = 1024,
    parameter int BURST_LEN = 16,
    parameter int LSB_FIRST = 1,
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  flush,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [IN_W-1:0]       din,
    output logic [IN_W*RATIO-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  burst_valid,
    output logic [CNT_W-1:0]      fifo_cnt,
    output logic                  overflow,
    output logic                  running
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int LW    = $clog2(RATIO);
    localparam int AW    = $clog2(DEPTH);

    localparam logic [LW-1:0]    LAST_LANE = LW'(RATIO - 1);
    localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] BURST_THR = CNT_W'(BURST_LEN);

    logic              running_q;
    logic              overflow_q;
    logic [LW-1:0]     lane_q;
    logic [OUT_W-1:0]  pack_q;
    logic              push_valid_q;
    logic [OUT_W-1:0]  push_data_q;
    logic              flush_pend_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [OUT_W-1:0]  mem [DEPTH];

    logic              space;
    logic              accept;
    logic              last_beat;
    logic              flush_req;
    logic              flush_load;
    logic              flush_pend_d;
    logic              load;
    logic              pop;
    logic [LW-1:0]     lane_d;
    logic [OUT_W-1:0]  merged;
    logic [CNT_W-1:0]  cnt_d;

    // Words in flight through the push register count against capacity,
    // so a push can never land on a full FIFO.
    assign space       = ({1'b0, cnt_q} + (CNT_W + 1)'(push_valid_q)) < DEPTH_C;
    assign din_ready   = running_q && space && !flush_pend_q;
    assign accept      = din_valid && din_ready;
    assign last_beat   = accept && (lane_q == LAST_LANE);
    assign lane_d      = last_beat ? '0 : (accept ? lane_q + 1'b1 : lane_q);
    assign flush_req   = flush || flush_pend_q;
    assign flush_load  = flush_req && (lane_d != '0) && space;
    assign flush_pend_d = flush_req && (lane_d != '0) && !space;
    assign load        = last_beat || flush_load;

    assign dout_valid  = (cnt_q != '0);
    assign pop         = dout_valid && dout_ready;
    assign dout        = mem[rd_ptr_q];
    assign fifo_cnt    = cnt_q;
    assign burst_valid = (cnt_q >= BURST_THR);
    assign overflow    = overflow_q;
    assign running     = running_q;

    always_comb begin
        cnt_d = cnt_q;
        if (push_valid_q && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (!push_valid_q && pop)
            cnt_d = cnt_q - 1'b1;
    end

    // Lane to bit-slice mapping depends on the configured beat order.
    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lane
            localparam int            POS     = (LSB_FIRST != 0) ? gi : (RATIO - 1 - gi);
            localparam logic [LW-1:0] LANE_ID = LW'(gi);
            assign merged[POS*IN_W +: IN_W] = (accept && (lane_q == LANE_ID))
                                              ? din : pack_q[POS*IN_W +: IN_W];
        end
    endgenerate

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            running_q    <= 1'b0;
            overflow_q   <= 1'b0;
            lane_q       <= '0;
            pack_q       <= '0;
            push_valid_q <= 1'b0;
            push_data_q  <= '0;
            flush_pend_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
        end else begin
            if (stop)
                running_q <= 1'b0;
            else if (start)
                running_q <= 1'b1;

            if (start)
                overflow_q <= 1'b0;
            else if (running_q && din_valid && !din_ready)
                overflow_q <= 1'b1;

            // Clearing the pack register on load is what zero-pads a flushed word.
            if (load) begin
                push_data_q <= merged;
                pack_q      <= '0;
            end else if (accept) begin
                pack_q <= merged;
            end
            lane_q       <= load ? '0 : lane_d;
            push_valid_q <= load;
            flush_pend_q <= flush_pend_d;

            if (push_valid_q)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (push_valid_q)
            mem[wr_ptr_q] <= push_data_q;
    end

endmodule
